// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C register sequencers
// (state encodings, default device address, stage timeout constant).
package i2c_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_BUS  = 3'd1,
      S_CMD       = 3'd2,
      S_REG_ADDR  = 3'd3,
      S_DATA      = 3'd4,
      S_WAIT_FREE = 3'd5,
      S_BACKOFF   = 3'd6
   } state_t;

   // VL53L0X time-of-flight sensor default 7-bit address
   localparam logic [6:0] VL53L0X_ADDR = 7'h29;

   // 1 ms expressed in 27 MHz clock cycles
   localparam int TIMEOUT_1MS_27MHZ = 27000;

endpackage

// File: rtl/i2c_stage_timer.sv
// i2c_stage_timer: loadable down-counter used as a per-stage watchdog.
// reload has priority; the count sticks at zero and expired flags it.
module i2c_stage_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reload,
   input  logic [WIDTH-1:0] reload_value,
   input  logic             enable,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // count down while enabled, restart on reload
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (reload) begin
         count <= reload_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/i2c_write_reg_burst.sv
// i2c_write_reg_burst: preload up to BUF_DEPTH payload bytes, then on start
// issue one write_multiple command (start + stop) and stream reg_address
// followed by the payload to the I2C master.
// Build option: I2C_WRITE_RETRY_EN adds NACK retries through S_BACKOFF.
//
// Handshakes (cmd and data_out): a transfer happens on a rising clk edge
// where valid and ready are both high; valid and its payload stay stable
// until that edge, and valid may stay high across consecutive transfers.
module i2c_write_reg_burst
   import i2c_pkg::*;
#(
   parameter int BUF_DEPTH      = 16,
   parameter int TIMEOUT_CYCLES = TIMEOUT_1MS_27MHZ,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] dev_address,
   input  logic [7:0] reg_address,
   input  logic [4:0] byte_count,
   input  logic       start,
   input  logic       load_en,
   input  logic [7:0] load_data,
   input  logic       load_clear,
   output logic [4:0] load_level,
   output logic       load_overflow,
   output logic [6:0] i2c_dev_address,
   output logic       i2c_cmd_start,
   output logic       i2c_cmd_write_multiple,
   output logic       i2c_cmd_stop,
   output logic       i2c_cmd_valid,
   input  logic       i2c_cmd_ready,
   output logic [7:0] i2c_data_out,
   output logic       i2c_data_out_valid,
   output logic       i2c_data_out_last,
   input  logic       i2c_data_out_ready,
   input  logic       i2c_bus_busy,
   input  logic       i2c_bus_active,
   input  logic       i2c_bus_control,
   input  logic       i2c_missed_ack,
   input  logic       i2c_relinquish,
   output logic       i2c_control,
   output logic       busy,
   output logic       done,
   output logic       message_failure,
   output logic [2:0] state_out
);

   localparam int         AW      = $clog2(BUF_DEPTH);
   localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [4:0] DEPTH_L = 5'(BUF_DEPTH);

   state_t     state, state_next;
   logic [7:0] buf_mem [BUF_DEPTH];
   logic [4:0] ptr, idx, count_q;
   logic [6:0] dev_q;
   logic [7:0] reg_q;
   logic       accept, fail, success, retry, data_fire;
   logic       reject, retry_ok, timer_expired, load_write;

   assign reject     = (byte_count > ptr) || (byte_count > DEPTH_L);
   assign load_write = (state == S_IDLE) && !load_clear && load_en && (ptr != DEPTH_L);

   // watchdog restarts on every state change and runs outside S_IDLE
   i2c_stage_timer #(.WIDTH(TW)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .reload       (state_next != state),
      .reload_value (TW'(TIMEOUT_CYCLES)),
      .enable       (state != S_IDLE),
      .expired      (timer_expired)
   );

`ifdef I2C_WRITE_RETRY_EN
   localparam int RW = $clog2(MAX_RETRIES + 1);
   logic [RW-1:0] retry_cnt;

   // NACK retry count, cleared by each accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         retry_cnt <= '0;
      end else if (accept) begin
         retry_cnt <= '0;
      end else if (retry) begin
         retry_cnt <= retry_cnt + 1'b1;
      end
   end

   assign retry_ok = (retry_cnt < RW'(MAX_RETRIES));
`else
   // without the retry build every NACK is final
   assign retry_ok = (MAX_RETRIES < 0);
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state: relinquish, then NACK, then timeout, then normal progress
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      fail       = 1'b0;
      success    = 1'b0;
      retry      = 1'b0;
      data_fire  = 1'b0;
      if (i2c_relinquish) begin
         state_next = S_IDLE;
      end else if (state == S_IDLE) begin
         if (start) begin
            if (reject) begin
               fail = 1'b1;
            end else begin
               accept     = 1'b1;
               state_next = S_WAIT_BUS;
            end
         end
      end else if (i2c_missed_ack && (state != S_BACKOFF)) begin
         // a NACK already counted is not re-counted while backing off
         if (retry_ok) begin
            retry      = 1'b1;
            state_next = S_BACKOFF;
         end else begin
            fail       = 1'b1;
            state_next = S_IDLE;
         end
      end else if (timer_expired) begin
         if (state == S_BACKOFF) begin
            state_next = S_WAIT_BUS;
         end else begin
            fail       = 1'b1;
            state_next = S_IDLE;
         end
      end else begin
         case (state)
            S_WAIT_BUS:  if (!i2c_bus_busy && !i2c_bus_active) state_next = S_CMD;
            S_CMD:       if (i2c_cmd_ready) state_next = S_REG_ADDR;
            S_REG_ADDR:  if (i2c_data_out_ready) state_next = (count_q == 5'd0) ? S_WAIT_FREE : S_DATA;
            S_DATA: begin
               if (i2c_data_out_ready) begin
                  data_fire = 1'b1;
                  if (i2c_data_out_last) state_next = S_WAIT_FREE;
               end
            end
            S_WAIT_FREE: begin
               if (!i2c_bus_busy && !i2c_bus_control) begin
                  success    = 1'b1;
                  state_next = S_IDLE;
               end
            end
            S_BACKOFF:   state_next = S_BACKOFF;
            default:     state_next = S_IDLE;
         endcase
      end
   end

   // outputs decoded from the current state only
   always_comb begin
      i2c_control        = 1'b0;
      i2c_cmd_valid      = 1'b0;
      i2c_dev_address    = 7'd0;
      i2c_data_out_valid = 1'b0;
      i2c_data_out_last  = 1'b0;
      i2c_data_out       = 8'd0;
      case (state)
         S_WAIT_BUS, S_WAIT_FREE, S_BACKOFF: begin
            i2c_control = 1'b1;
         end
         S_CMD: begin
            i2c_control     = 1'b1;
            i2c_cmd_valid   = 1'b1;
            i2c_dev_address = dev_q;
         end
         S_REG_ADDR: begin
            i2c_control        = 1'b1;
            i2c_data_out_valid = 1'b1;
            i2c_data_out       = reg_q;
            i2c_data_out_last  = (count_q == 5'd0);
         end
         S_DATA: begin
            i2c_control        = 1'b1;
            i2c_data_out_valid = 1'b1;
            i2c_data_out       = buf_mem[idx[AW-1:0]];
            i2c_data_out_last  = (idx == (count_q - 5'd1));
         end
         default: ;
      endcase
   end

   assign i2c_cmd_start          = i2c_cmd_valid;
   assign i2c_cmd_write_multiple = i2c_cmd_valid;
   assign i2c_cmd_stop           = i2c_cmd_valid;
   assign busy                   = (state != S_IDLE);
   assign state_out              = state;
   assign load_level             = ptr;

   // transaction latches, payload index and result pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         dev_q           <= 7'd0;
         reg_q           <= 8'd0;
         count_q         <= 5'd0;
         idx             <= 5'd0;
         done            <= 1'b0;
         message_failure <= 1'b0;
      end else begin
         done            <= success;
         message_failure <= fail;
         if (accept) begin
            dev_q   <= dev_address;
            reg_q   <= reg_address;
            count_q <= byte_count;
            idx     <= 5'd0;
         end else if (retry) begin
            idx <= 5'd0;
         end else if (data_fire) begin
            idx <= idx + 5'd1;
         end
      end
   end

   // buffer write pointer and sticky overflow, only changed while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr           <= 5'd0;
         load_overflow <= 1'b0;
      end else if (state == S_IDLE) begin
         if (load_clear) begin
            ptr           <= 5'd0;
            load_overflow <= 1'b0;
         end else if (load_en) begin
            if (ptr == DEPTH_L) begin
               load_overflow <= 1'b1;
            end else begin
               ptr <= ptr + 5'd1;
            end
         end
      end
   end

   // payload storage; kept across transactions so a write can be repeated
   always_ff @(posedge clk) begin
      if (load_write) begin
         buf_mem[ptr[AW-1:0]] <= load_data;
      end
   end

endmodule
